// File: rtl/instruction_queue_pkg.sv
// Shared constants for the instruction queue: default field widths,
// opcode slice positions and the occupancy-count width helper.
package instruction_queue_pkg;

    localparam int IQ_DATA_WIDTH = 8;
    localparam int IQ_ADDR_WIDTH = 5;

    // Opcode occupies the bits above the operand field
    localparam int IQ_OPC_MSB = IQ_DATA_WIDTH - 1;
    localparam int IQ_OPC_LSB = IQ_ADDR_WIDTH;
    localparam int IQ_OPC_W   = IQ_DATA_WIDTH - IQ_ADDR_WIDTH;

    // Count must represent 0..depth inclusive
    function automatic int iq_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iq_fifo_mem.sv
// Queue storage: one synchronous write port, asynchronous read of the head.
module iq_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the pushed word; storage is data only, so it is never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// Instruction FIFO feeding the IR stage. Fetch pushes words, execute
// advances the IR stage; an empty queue lets a same-cycle push bypass
// straight into IR. Flush discards everything queued and in IR.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DATA_WIDTH = IQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = IQ_ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = iq_cnt_width(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_ir,
    input  logic [DATA_WIDTH-1:0]            inst_in,
    input  logic                             advance,
    input  logic                             flush,
    output logic [DATA_WIDTH-ADDR_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]            operand,
    output logic                             ir_valid,
    output logic                             q_ready,
    output logic [CNT_W-1:0]                 q_count,
    output logic                             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]         wr_ptr_p0;
    logic [AW-1:0]         rd_ptr_p0;
    logic [CNT_W-1:0]      count_p0;
    logic [DATA_WIDTH-1:0] head_word;
    logic [DATA_WIDTH-1:0] ir_p1;
    logic                  vld_p1;
    logic                  ovf_p1;

    logic q_empty;
    logic q_full;
    logic do_pop;
    logic do_bypass;
    logic push_req;
    logic do_push;
    logic do_drop;

    // Queue decisions; flush gates every state-changing action
    always_comb begin
        q_empty   = (count_p0 == '0);
        q_full    = (count_p0 == CNT_W'(DEPTH));
        do_pop    = !flush && advance && !q_empty;
        do_bypass = !flush && advance && q_empty && ld_ir;
        push_req  = !flush && ld_ir && !do_bypass;
        do_push   = push_req && (!q_full || do_pop);
        do_drop   = push_req && q_full && !do_pop;
    end

    iq_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr_p0),
        .wdata (inst_in),
        .raddr (rd_ptr_p0),
        .rdata (head_word)
    );

    // ---- queue stage p0: pointers and occupancy ----
    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            if (do_push) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
            if (do_pop)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
            if (do_push && !do_pop)      count_p0 <= count_p0 + 1'b1;
            else if (do_pop && !do_push) count_p0 <= count_p0 - 1'b1;
        end
    end

    // ---- IR stage p1: loaded from head or bypass, holds when starved ----
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            ir_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (do_pop) begin
            ir_p1  <= head_word;
            vld_p1 <= 1'b1;
        end else if (do_bypass) begin
            ir_p1  <= inst_in;
            vld_p1 <= 1'b1;
        end else if (advance) begin
            vld_p1 <= 1'b0;
        end
    end

    // Dropped push is flagged for exactly the following cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_p1 <= 1'b0;
        end else begin
            ovf_p1 <= do_drop;
        end
    end

    assign opcode   = ir_p1[DATA_WIDTH-1:ADDR_WIDTH];
    assign operand  = ir_p1[ADDR_WIDTH-1:0];
    assign ir_valid = vld_p1;
    assign q_ready  = !q_full;
    assign q_count  = count_p0;
    assign overflow = ovf_p1;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: reset, bypass, fill/drain with
// overflow, full push+pop with wrap, flush, and mid-operation reset.
module tb_instruction_queue;
    import instruction_queue_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                ld_ir;
    logic [7:0]          inst_in;
    logic                advance;
    logic                flush;
    logic [IQ_OPC_W-1:0] opcode;
    logic [4:0]          operand;
    logic                ir_valid;
    logic                q_ready;
    logic [2:0]          q_count;
    logic                overflow;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_queue dut (
        .clk      (clk),
        .rst      (rst),
        .ld_ir    (ld_ir),
        .inst_in  (inst_in),
        .advance  (advance),
        .flush    (flush),
        .opcode   (opcode),
        .operand  (operand),
        .ir_valid (ir_valid),
        .q_ready  (q_ready),
        .q_count  (q_count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        ld_ir = 1'b1; advance = 1'b0; inst_in = w;
        step();
        ld_ir = 1'b0; inst_in = 8'hxx;
    endtask

    task automatic adv_chk(input string tag, input logic [7:0] exp_ir);
        ld_ir = 1'b0; advance = 1'b1;
        step();
        advance = 1'b0;
        chk(tag, {24'd0, opcode, operand}, {24'd0, exp_ir});
        chk({tag, "_vld"}, {31'd0, ir_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; ld_ir = 1'b1; inst_in = 8'hFF; advance = 1'b0; flush = 1'b0;
        step();
        step();
        chk("rst_ir",    {24'd0, opcode, operand}, 32'h00);
        chk("rst_vld",   {31'd0, ir_valid}, 32'd0);
        chk("rst_cnt",   {29'd0, q_count}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        chk("rst_ready", {31'd0, q_ready}, 32'd1);

        // Bypass into IR from empty queue
        rst = 1'b1; ld_ir = 1'b1; advance = 1'b1; inst_in = 8'hCC;
        step();
        ld_ir = 1'b0; advance = 1'b0; inst_in = 8'hxx;
        chk("byp_ir",  {24'd0, opcode, operand}, 32'hCC);
        chk("byp_opc", {29'd0, opcode}, 32'd6);
        chk("byp_opr", {27'd0, operand}, 32'h0C);
        chk("byp_vld", {31'd0, ir_valid}, 32'd1);
        chk("byp_cnt", {29'd0, q_count}, 32'd0);

        // Fill to capacity
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("fill_cnt",   {29'd0, q_count}, 32'd4);
        chk("fill_ready", {31'd0, q_ready}, 32'd0);
        chk("fill_ovf",   {31'd0, overflow}, 32'd0);
        chk("fill_ir",    {24'd0, opcode, operand}, 32'hCC);

        // Push into full queue is dropped and flagged for one cycle
        push(8'h55);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_cnt", {29'd0, q_count}, 32'd4);
        step();
        chk("drop_ovf_clr", {31'd0, overflow}, 32'd0);

        // Drain in order, then starve
        adv_chk("drain0", 8'h11);
        adv_chk("drain1", 8'h22);
        adv_chk("drain2", 8'h33);
        adv_chk("drain3", 8'h44);
        chk("drain_cnt", {29'd0, q_count}, 32'd0);
        advance = 1'b1;
        step();
        advance = 1'b0;
        chk("starve_vld", {31'd0, ir_valid}, 32'd0);
        chk("starve_ir",  {24'd0, opcode, operand}, 32'h44);

        // Full queue with simultaneous push and pop
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        ld_ir = 1'b1; advance = 1'b1; inst_in = 8'hAA;
        step();
        ld_ir = 1'b0; advance = 1'b0; inst_in = 8'hxx;
        chk("pp_ir",  {24'd0, opcode, operand}, 32'h11);
        chk("pp_cnt", {29'd0, q_count}, 32'd4);
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        adv_chk("wrap0", 8'h22);
        adv_chk("wrap1", 8'h33);
        adv_chk("wrap2", 8'h44);
        adv_chk("wrap3", 8'hAA);
        chk("wrap_cnt", {29'd0, q_count}, 32'd0);

        // Flush with concurrent push
        push(8'h66); push(8'h77);
        chk("pre_flush_cnt", {29'd0, q_count}, 32'd2);
        chk("pre_flush_vld", {31'd0, ir_valid}, 32'd1);
        flush = 1'b1; ld_ir = 1'b1; inst_in = 8'hEE;
        step();
        flush = 1'b0; ld_ir = 1'b0; inst_in = 8'hxx;
        chk("flush_cnt", {29'd0, q_count}, 32'd0);
        chk("flush_vld", {31'd0, ir_valid}, 32'd0);
        chk("flush_ir",  {24'd0, opcode, operand}, 32'h00);
        chk("flush_ovf", {31'd0, overflow}, 32'd0);
        advance = 1'b1;
        step();
        advance = 1'b0;
        chk("flush_empty_vld", {31'd0, ir_valid}, 32'd0);
        chk("flush_empty_ir",  {24'd0, opcode, operand}, 32'h00);

        // Reset in the middle of operation
        push(8'h12); push(8'h34); push(8'h56);
        chk("mid_cnt", {29'd0, q_count}, 32'd3);
        rst = 1'b0; advance = 1'b1;
        step();
        chk("mrst_ir",  {24'd0, opcode, operand}, 32'h00);
        chk("mrst_vld", {31'd0, ir_valid}, 32'd0);
        chk("mrst_cnt", {29'd0, q_count}, 32'd0);
        chk("mrst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b1; ld_ir = 1'b1; advance = 1'b1; inst_in = 8'h5A;
        step();
        ld_ir = 1'b0; advance = 1'b0; inst_in = 8'hxx;
        chk("post_rst_ir",  {24'd0, opcode, operand}, 32'h5A);
        chk("post_rst_vld", {31'd0, ir_valid}, 32'd1);
        chk("post_rst_cnt", {29'd0, q_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
